// File: rtl/txn_seq_pkg.sv
// Shared constants for the scripted bus master: FSM encodings, ISSUE length
// and the default address table.
package txn_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_ISSUE = 2'd2;
  localparam state_t ST_WAIT  = 2'd3;

  // dvalid is held for exactly this many cycles per transaction
  localparam int ISSUE_LEN = 2;

  // Entry 0 is the least significant slice
  localparam logic [63:0] DEFAULT_ADDRS = {16'h0009, 16'h1001, 16'h2002, 16'h0009};

endpackage

// File: rtl/txn_seq_buf.sv
// Split data buffer: one write port (FSM beats host), registered LOAD and
// debug read ports, whole array cleared by reset.
module txn_seq_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 32,
  localparam int BW        = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fsm_we,
  input  logic [BW-1:0]         fsm_waddr,
  input  logic [DATA_WIDTH-1:0] fsm_wdata,
  input  logic                  host_we,
  input  logic [BW-1:0]         host_waddr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  ld_rd_en,
  input  logic [BW-1:0]         ld_raddr,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic [BW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  we_d;
  logic [BW-1:0]         waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] ld_rdata_d, ld_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_data_d, dbg_data_q;

  // Write-port arbitration and next values of the two read registers
  always_comb begin
    we_d       = 1'b0;
    waddr_d    = host_waddr;
    wdata_d    = host_wdata;
    if (fsm_we) begin
      we_d    = 1'b1;
      waddr_d = fsm_waddr;
      wdata_d = fsm_wdata;
    end else if (host_we) begin
      we_d    = 1'b1;
    end
    ld_rdata_d = ld_rd_en ? mem_q[ld_raddr] : ld_rdata_q;
    dbg_data_d = mem_q[dbg_addr];
  end

  // Array storage; reads above see the pre-write contents of the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_d) begin
      mem_q[waddr_d] <= wdata_d;
    end
  end

  // Registered read ports
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_rdata_q <= '0;
      dbg_data_q <= '0;
    end else begin
      ld_rdata_q <= ld_rdata_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign ld_rdata = ld_rdata_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: rtl/txn_sequencer.sv
// Scripted bus master front-end: walks an address table, moving data between
// the split buffer (writes from the lower half, reads into the upper half)
// and master_port, with timeout, abort, host preload and debug readout.
module txn_sequencer
  import txn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TXN    = 4,
  parameter int BUF_DEPTH  = 32,
  parameter int TIMEOUT    = 255,
  parameter logic [ADDR_WIDTH*NUM_TXN-1:0] ADDRS = DEFAULT_ADDRS,
  localparam int BW = $clog2(BUF_DEPTH),
  localparam int TW = $clog2(NUM_TXN)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  run_all,
  input  logic                  abort,
  input  logic                  ld_en,
  input  logic [BW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [BW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  ready,
  output logic                  done,
  output logic                  timeout_err,
  output logic [TW-1:0]         txn_idx,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (ISSUE_LEN > 1) ? $clog2(ISSUE_LEN) : 1;

  state_t        state_d, state_q;
  logic          dmode_d, dmode_q;
  logic          run_all_d, run_all_q;
  logic          timeout_err_d, timeout_err_q;
  logic          done_d, done_q;
  logic [TW-1:0] txn_idx_d, txn_idx_q;
  logic [CW-1:0] wait_cnt_d, wait_cnt_q;
  logic [IW-1:0] issue_cnt_d, issue_cnt_q;
  logic          fsm_we;
  logic          last_idx;
  logic [BW-1:0] buf_idx;

  // Table lookup for the current index and the buffer slot it maps to
  always_comb begin
    daddr   = ADDRS[ADDR_WIDTH*int'(txn_idx_q) +: ADDR_WIDTH];
    buf_idx = {~dmode_q, daddr[BW-2:0]};
  end

  // Sequencer next-state logic; abort overrides everything at the end
  always_comb begin
    state_d       = state_q;
    dmode_d       = dmode_q;
    run_all_d     = run_all_q;
    timeout_err_d = timeout_err_q;
    txn_idx_d     = txn_idx_q;
    wait_cnt_d    = wait_cnt_q;
    issue_cnt_d   = issue_cnt_q;
    done_d        = 1'b0;
    fsm_we        = 1'b0;
    last_idx      = (txn_idx_q == TW'(NUM_TXN - 1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          dmode_d       = mode;
          run_all_d     = run_all;
          timeout_err_d = 1'b0;
          wait_cnt_d    = '0;
        end
      end
      ST_LOAD: begin
        state_d     = ST_ISSUE;
        issue_cnt_d = '0;
      end
      ST_ISSUE: begin
        if (issue_cnt_q == IW'(ISSUE_LEN - 1)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          issue_cnt_d = issue_cnt_q + IW'(1);
        end
      end
      default: begin
        if (dready) begin
          fsm_we    = ~dmode_q;
          txn_idx_d = last_idx ? '0 : txn_idx_q + TW'(1);
          if (run_all_q && !last_idx) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      done_d        = 1'b0;
      fsm_we        = 1'b0;
      txn_idx_d     = txn_idx_q;
      timeout_err_d = timeout_err_q;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      dmode_q       <= 1'b0;
      run_all_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
      txn_idx_q     <= '0;
      wait_cnt_q    <= '0;
      issue_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      dmode_q       <= dmode_d;
      run_all_q     <= run_all_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
      txn_idx_q     <= txn_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  // The buffer's LOAD read register doubles as dwdata, so it stays stable
  // until the next LOAD
  txn_seq_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rstn       (rstn),
    .fsm_we     (fsm_we),
    .fsm_waddr  (buf_idx),
    .fsm_wdata  (drdata),
    .host_we    (ld_en && (state_q == ST_IDLE)),
    .host_waddr (ld_addr),
    .host_wdata (ld_data),
    .ld_rd_en   (state_q == ST_LOAD),
    .ld_raddr   (buf_idx),
    .ld_rdata   (dwdata),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  assign ready       = (state_q == ST_IDLE);
  assign dvalid      = (state_q == ST_ISSUE);
  assign dmode       = dmode_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign txn_idx     = txn_idx_q;

endmodule

// File: tb/tb_txn_sequencer.sv
// Directed bench for txn_sequencer. Inputs change and outputs are sampled on
// the falling clock edge, so every step is one full cycle of the DUT.
module tb_txn_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, mode = 1'b0, run_all = 1'b0, abort = 1'b0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;
  logic        ready, done, timeout_err, dmode, dvalid;
  logic [1:0]  txn_idx;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dready = 1'b0;
  logic [7:0]  drdata = '0;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_buf [32];
  logic [15:0] exp_addr [4];
  logic [7:0]  resp [4];

  always #5 clk = ~clk;

  // Entry 0 is the least significant slice: visit order 0009,1001,2002,0009
  txn_sequencer #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .NUM_TXN    (4),
    .BUF_DEPTH  (32),
    .TIMEOUT    (5),
    .ADDRS      ({16'h0009, 16'h2002, 16'h1001, 16'h0009})
  ) dut (
    .clk (clk), .rstn (rstn), .start (start), .mode (mode), .run_all (run_all),
    .abort (abort), .ld_en (ld_en), .ld_addr (ld_addr), .ld_data (ld_data),
    .dbg_addr (dbg_addr), .dbg_data (dbg_data), .ready (ready), .done (done),
    .timeout_err (timeout_err), .txn_idx (txn_idx), .daddr (daddr),
    .dwdata (dwdata), .dmode (dmode), .dvalid (dvalid), .dready (dready),
    .drdata (drdata)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", ready); end
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL reset_dvalid got=%0h exp=0", dvalid); end
    checks++; if (dmode !== 1'b0) begin failures++; $display("FAIL reset_dmode got=%0h exp=0", dmode); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0h exp=0", timeout_err); end
    checks++; if (txn_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0h exp=0", txn_idx); end
    checks++; if (dwdata !== 8'h00) begin failures++; $display("FAIL reset_dwdata got=%0h exp=0", dwdata); end
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL reset_dbg got=%0h exp=0", dbg_data); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    ld_en = 1'b1; ld_addr = 5'd9; ld_data = 8'hA5;
    step();
    ld_en = 1'b0; start = 1'b1; mode = 1'b1; run_all = 1'b0;
    exp_buf[9] = 8'hA5;
    step();  // LOAD
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_load got=%0h exp=0", ready); end
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL single_dvalid_load got=%0h exp=0", dvalid); end
    checks++; if (daddr !== 16'h0009) begin failures++; $display("FAIL single_daddr got=%0h exp=0009", daddr); end
    checks++; if (dmode !== 1'b1) begin failures++; $display("FAIL single_dmode got=%0h exp=1", dmode); end
    step();  // ISSUE 1
    checks++; if (dvalid !== 1'b1) begin failures++; $display("FAIL single_dvalid_i1 got=%0h exp=1", dvalid); end
    checks++; if (dwdata !== 8'hA5) begin failures++; $display("FAIL single_dwdata got=%0h exp=a5", dwdata); end
    step();  // ISSUE 2
    checks++; if (dvalid !== 1'b1) begin failures++; $display("FAIL single_dvalid_i2 got=%0h exp=1", dvalid); end
    step();  // WAIT
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL single_dvalid_wait got=%0h exp=0", dvalid); end
    checks++; if (dwdata !== 8'hA5) begin failures++; $display("FAIL single_dwdata_wait got=%0h exp=a5", dwdata); end
    dready = 1'b1;
    step();
    dready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%0h exp=1", done); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_end got=%0h exp=1", ready); end
    checks++; if (txn_idx !== 2'd1) begin failures++; $display("FAIL single_idx got=%0h exp=1", txn_idx); end
    $display("txn write addr=%04h data=%02h", 16'h0009, 8'hA5);
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%0h exp=0", done); end
  endtask

  task automatic test_run_all_read();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    checks++; if (txn_idx !== 2'd0) begin failures++; $display("FAIL runall_idx_start got=%0h exp=0", txn_idx); end
    start = 1'b1; mode = 1'b0; run_all = 1'b1;
    step();  // LOAD
    start = 1'b0; run_all = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();  // ISSUE 1
      checks++; if (dvalid !== 1'b1) begin failures++; $display("FAIL runall_dvalid k=%0d got=%0h exp=1", k, dvalid); end
      checks++; if (daddr !== exp_addr[k]) begin failures++; $display("FAIL runall_daddr k=%0d got=%0h exp=%0h", k, daddr, exp_addr[k]); end
      checks++; if (dmode !== 1'b0) begin failures++; $display("FAIL runall_dmode k=%0d got=%0h exp=0", k, dmode); end
      step();  // ISSUE 2
      step();  // WAIT
      dready = 1'b1; drdata = resp[k];
      exp_buf[{1'b1, exp_addr[k][3:0]}] = resp[k];
      $display("txn read addr=%04h data=%02h", exp_addr[k], resp[k]);
      step();
      dready = 1'b0;
      checks++; if (done !== (k == 3)) begin failures++; $display("FAIL runall_done k=%0d got=%0h exp=%0h", k, done, (k == 3)); end
    end
    checks++; if (txn_idx !== 2'd0) begin failures++; $display("FAIL runall_idx_end got=%0h exp=0", txn_idx); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL runall_ready got=%0h exp=1", ready); end
    dbg_addr = 5'd25;
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL runall_done_after got=%0h exp=0", done); end
    checks++; if (dbg_data !== 8'h44) begin failures++; $display("FAIL runall_buf25 got=%0h exp=44", dbg_data); end
    dbg_addr = 5'd17;
    step();
    checks++; if (dbg_data !== 8'h22) begin failures++; $display("FAIL runall_buf17 got=%0h exp=22", dbg_data); end
    dbg_addr = 5'd18;
    step();
    checks++; if (dbg_data !== 8'h33) begin failures++; $display("FAIL runall_buf18 got=%0h exp=33", dbg_data); end
  endtask

  task automatic test_timeout();
    start = 1'b1; mode = 1'b0; run_all = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      start = 1'b0;
    end
    // fifth WAIT cycle: not yet expired
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%0h exp=0", timeout_err); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL tmo_ready_early got=%0h exp=0", ready); end
    step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_set got=%0h exp=1", timeout_err); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL tmo_ready got=%0h exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL tmo_done got=%0h exp=0", done); end
    checks++; if (txn_idx !== 2'd0) begin failures++; $display("FAIL tmo_idx got=%0h exp=0", txn_idx); end
    $display("txn timeout addr=%04h", daddr);
    step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0h exp=1", timeout_err); end
    start = 1'b1;
    step();  // LOAD
    start = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%0h exp=0", timeout_err); end
    step(); step(); step();  // WAIT
    dready = 1'b1; drdata = 8'h5C;
    exp_buf[25] = 8'h5C;
    step();
    dready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL tmo_retry_done got=%0h exp=1", done); end
    checks++; if (txn_idx !== 2'd1) begin failures++; $display("FAIL tmo_retry_idx got=%0h exp=1", txn_idx); end
    $display("txn read addr=%04h data=%02h", 16'h0009, 8'h5C);
  endtask

  task automatic test_abort();
    start = 1'b1; mode = 1'b0; run_all = 1'b0;
    step();  // LOAD
    start = 1'b0;
    step();  // ISSUE 1
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_issue_ready got=%0h exp=1", ready); end
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL abort_issue_dvalid got=%0h exp=0", dvalid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_issue_done got=%0h exp=0", done); end
    checks++; if (txn_idx !== 2'd1) begin failures++; $display("FAIL abort_issue_idx got=%0h exp=1", txn_idx); end
    $display("txn abort in ISSUE addr=%04h", daddr);
    start = 1'b1;
    step();  // LOAD
    start = 1'b0;
    step(); step(); step();  // WAIT
    abort = 1'b1; dready = 1'b1; drdata = 8'hEE;
    step();
    abort = 1'b0; dready = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_wait_ready got=%0h exp=1", ready); end
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL abort_wait_dvalid got=%0h exp=0", dvalid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_wait_done got=%0h exp=0", done); end
    checks++; if (txn_idx !== 2'd1) begin failures++; $display("FAIL abort_wait_idx got=%0h exp=1", txn_idx); end
    $display("txn abort in WAIT addr=%04h", daddr);
    dbg_addr = 5'd17;
    step();
    checks++; if (dbg_data !== 8'h22) begin failures++; $display("FAIL abort_buf17 got=%0h exp=22", dbg_data); end
  endtask

  task automatic test_ld_ignored();
    start = 1'b1; mode = 1'b1; run_all = 1'b0;
    step();  // LOAD
    start = 1'b0;
    step(); step(); step();  // WAIT
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 8'h77;
    step(); step();
    ld_en = 1'b0;
    dready = 1'b1;
    step();
    dready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ldign_done got=%0h exp=1", done); end
    checks++; if (txn_idx !== 2'd2) begin failures++; $display("FAIL ldign_idx got=%0h exp=2", txn_idx); end
    $display("txn write addr=%04h data=%02h", 16'h1001, 8'h00);
  endtask

  task automatic test_start_with_load();
    ld_en = 1'b1; ld_addr = 5'd2; ld_data = 8'hC3;
    start = 1'b1; mode = 1'b1; run_all = 1'b0;
    exp_buf[2] = 8'hC3;
    step();  // LOAD
    ld_en = 1'b0; start = 1'b0;
    step();  // ISSUE 1
    checks++; if (dwdata !== 8'hC3) begin failures++; $display("FAIL stld_dwdata got=%0h exp=c3", dwdata); end
    checks++; if (daddr !== 16'h2002) begin failures++; $display("FAIL stld_daddr got=%0h exp=2002", daddr); end
    step(); step();  // WAIT
    dready = 1'b1;
    step();
    dready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stld_done got=%0h exp=1", done); end
    checks++; if (txn_idx !== 2'd3) begin failures++; $display("FAIL stld_idx got=%0h exp=3", txn_idx); end
    $display("txn write addr=%04h data=%02h", 16'h2002, 8'hC3);
  endtask

  task automatic test_dbg_sweep();
    ld_en = 1'b1; ld_addr = 5'd4; ld_data = 8'h5A; dbg_addr = 5'd4;
    step();
    ld_en = 1'b0;
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL dbg_same_cycle got=%0h exp=00", dbg_data); end
    step();
    checks++; if (dbg_data !== 8'h5A) begin failures++; $display("FAIL dbg_after_write got=%0h exp=5a", dbg_data); end
    exp_buf[4] = 8'h5A;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      step();
      checks++; if (dbg_data !== exp_buf[a]) begin failures++; $display("FAIL dbg_sweep[%0d] got=%0h exp=%0h", a, dbg_data, exp_buf[a]); end
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; mode = 1'b0; run_all = 1'b1;
    step();  // LOAD
    start = 1'b0; run_all = 1'b0;
    step();  // ISSUE 1
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0h exp=1", ready); end
    checks++; if (dvalid !== 1'b0) begin failures++; $display("FAIL midrst_dvalid got=%0h exp=0", dvalid); end
    checks++; if (dmode !== 1'b0) begin failures++; $display("FAIL midrst_dmode got=%0h exp=0", dmode); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0h exp=0", done); end
    checks++; if (txn_idx !== 2'd0) begin failures++; $display("FAIL midrst_idx got=%0h exp=0", txn_idx); end
    checks++; if (dwdata !== 8'h00) begin failures++; $display("FAIL midrst_dwdata got=%0h exp=0", dwdata); end
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL midrst_dbg got=%0h exp=0", dbg_data); end
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      step();
      checks++; if (dbg_data !== exp_buf[a]) begin failures++; $display("FAIL midrst_buf[%0d] got=%0h exp=00", a, dbg_data); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    exp_addr[0] = 16'h0009; exp_addr[1] = 16'h1001;
    exp_addr[2] = 16'h2002; exp_addr[3] = 16'h0009;
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    test_reset();
    test_single_write();
    test_run_all_read();
    test_timeout();
    test_abort();
    test_ld_ignored();
    test_start_with_load();
    test_dbg_sweep();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
